loop_driver_deadtime_ctrl: RTL and testbench

LOOP_DRIVER_DEADTIME_CTRL -- requirements
Module: loop_driver_deadtime_ctrl

---
 rtl/loop_driver_pkg.sv | 16 +
 rtl/loop_dt_counter.sv | 18 +
 rtl/loop_driver_deadtime_ctrl.sv | 76 +++++++
 tb/tb_loop_driver_deadtime_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/loop_driver_pkg.sv
// loop_driver_pkg: shared state encoding and default sizing for the loop driver dead-time controller.
package loop_driver_pkg;
  localparam int DT_W_DEF = 6;
  localparam int TO_CYC_DEF = 63;
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_DT_TOP = 3'd1,
    ST_TOP    = 3'd2,
    ST_DT_BOT = 3'd3,
    ST_BOT    = 3'd4,
    ST_FLT    = 3'd5
  } state_e;
  function automatic logic is_dt(input state_e s);
    return s == ST_DT_TOP || s == ST_DT_BOT;
  endfunction
endpackage

// File: rtl/loop_dt_counter.sv
// loop_dt_counter: loadable dead-time down-counter that stops at zero and flags it.
module loop_dt_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/loop_driver_deadtime_ctrl.sv
// loop_driver_deadtime_ctrl: half-bridge gate sequencer with dead time, feedback interlock and sticky fault.
module loop_driver_deadtime_ctrl
  import loop_driver_pkg::*;
#(
  parameter int DT_W   = DT_W_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            fb_top,
  input  logic            fb_bot,
  input  logic            fault_clr,
  output logic            top_on,
  output logic            bot_on,
  output logic            fault,
  output logic [2:0]      state_o
);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TO_CYC);
  state_e state_q, state_d;
  logic pwm_q, top_q, bot_q, flt_q, cnt_zero, load, opp_fb, to_run;
  logic [TW-1:0] to_q, to_d;
  always_comb begin
    opp_fb = state_q == ST_DT_TOP ? fb_bot : fb_top;
    state_d = state_q;
    if (state_q == ST_FLT) state_d = (fault_clr && !fb_top && !fb_bot) ? ST_OFF : ST_FLT;
    else if (fb_top && fb_bot) state_d = ST_FLT;
    else if (!en) state_d = ST_OFF;
    else
      case (state_q)
        ST_OFF:    state_d = pwm_q ? ST_DT_TOP : ST_DT_BOT;
        ST_DT_TOP: state_d = to_q == TO_MAX ? ST_FLT : !pwm_q ? ST_DT_BOT :
                             (cnt_zero && !fb_bot) ? ST_TOP : ST_DT_TOP;
        ST_TOP:    state_d = pwm_q ? ST_TOP : ST_DT_BOT;
        ST_DT_BOT: state_d = to_q == TO_MAX ? ST_FLT : pwm_q ? ST_DT_TOP :
                             (cnt_zero && !fb_top) ? ST_BOT : ST_DT_BOT;
        ST_BOT:    state_d = pwm_q ? ST_DT_TOP : ST_BOT;
        default:   state_d = ST_FLT;
      endcase
    load = is_dt(state_d) && state_d != state_q;
    // Timeout only accumulates while waiting in the same dead-time state on a stuck opposite gate.
    to_run = is_dt(state_d) && !load && opp_fb;
    to_d = !to_run ? '0 : to_q == TO_MAX ? to_q : to_q + 1'b1;
  end
  always_ff @(posedge CELCLK)
    if (CELRST) begin
      state_q <= ST_OFF;
      pwm_q   <= 1'b0;
      top_q   <= 1'b0;
      bot_q   <= 1'b0;
      flt_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_in;
      top_q   <= state_d == ST_TOP;
      bot_q   <= state_d == ST_BOT;
      flt_q   <= state_d == ST_FLT;
      to_q    <= to_d;
    end
  loop_dt_counter #(.W(DT_W)) u_dt (
    .clk(CELCLK),
    .rst(CELRST),
    .load_i(load),
    .dec_i(is_dt(state_q)),
    .val_i(dt_cfg),
    .zero_o(cnt_zero)
  );
  assign top_on  = top_q;
  assign bot_on  = bot_q;
  assign fault   = flt_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_loop_driver_deadtime_ctrl.sv
// tb_loop_driver_deadtime_ctrl: vector table plus corner-case sequences for the dead-time controller.
module tb_loop_driver_deadtime_ctrl;
  logic CELCLK, CELRST, en, pwm_in, fault_clr, ft_frc, fb_frc;
  logic [5:0] dt_cfg;
  logic fb_top, fb_bot, top_on, bot_on, fault;
  logic [2:0] state_o;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic en, pwm;
    logic [5:0] dt;
    logic top, bot, flt;
    logic [2:0] st;
  } vec_t;
  vec_t tbl[19];
  vec_t exp_q[$];
  vec_t e;
  int first;
  logic seen;
  // Gate sense follows the commanded driver, with forces to model stuck or shorted gates.
  assign fb_top = top_on | ft_frc;
  assign fb_bot = bot_on | fb_frc;
  loop_driver_deadtime_ctrl dut (
    .CELCLK(CELCLK), .CELRST(CELRST), .en(en), .pwm_in(pwm_in), .dt_cfg(dt_cfg),
    .fb_top(fb_top), .fb_bot(fb_bot), .fault_clr(fault_clr),
    .top_on(top_on), .bot_on(bot_on), .fault(fault), .state_o(state_o)
  );
  initial CELCLK = 1'b0;
  always #5 CELCLK = ~CELCLK;
  always @(negedge CELCLK) begin
    n_vec++;
    if (top_on && bot_on) begin
      n_err++;
      $display("FAIL overlap: top_on=%0b bot_on=%0b required not both 1", top_on, bot_on);
    end
  end
  function automatic vec_t v(input int en_v, pwm_v, dt_v, t, b, f, s);
    vec_t r;
    r.en = 1'(en_v); r.pwm = 1'(pwm_v); r.dt = 6'(dt_v);
    r.top = 1'(t); r.bot = 1'(b); r.flt = 1'(f); r.st = 3'(s);
    return r;
  endfunction
  task automatic step();
    @(posedge CELCLK);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask
  task automatic go_bot();
    pwm_in = 1'b0;
    dt_cfg = 6'd0;
    for (int i = 0; i < 10 && !bot_on; i++) step();
    chk("go_bot", bot_on, 1);
  endtask
  initial begin
    CELRST = 1; en = 0; pwm_in = 0; dt_cfg = 0; ft_frc = 0; fb_frc = 0; fault_clr = 0;
    step(); step();
    chk("rst_top", top_on, 0); chk("rst_bot", bot_on, 0);
    chk("rst_fault", fault, 0); chk("rst_state", state_o, 0);
    CELRST = 0;
    tbl[0]  = v(1,1,2, 0,0,0,3); tbl[1]  = v(1,1,2, 0,0,0,1);
    tbl[2]  = v(1,1,2, 0,0,0,1); tbl[3]  = v(1,1,2, 0,0,0,1);
    tbl[4]  = v(1,1,2, 1,0,0,2); tbl[5]  = v(1,0,2, 1,0,0,2);
    tbl[6]  = v(1,0,0, 0,0,0,3); tbl[7]  = v(1,0,0, 0,1,0,4);
    tbl[8]  = v(1,1,1, 0,1,0,4); tbl[9]  = v(1,1,1, 0,0,0,1);
    tbl[10] = v(1,1,1, 0,0,0,1); tbl[11] = v(1,1,1, 1,0,0,2);
    tbl[12] = v(0,1,1, 0,0,0,0); tbl[13] = v(0,1,1, 0,0,0,0);
    tbl[14] = v(1,1,3, 0,0,0,1); tbl[15] = v(1,1,3, 0,0,0,1);
    tbl[16] = v(1,1,3, 0,0,0,1); tbl[17] = v(1,1,3, 0,0,0,1);
    tbl[18] = v(1,1,3, 1,0,0,2);
    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en; pwm_in = tbl[i].pwm; dt_cfg = tbl[i].dt;
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_top", i), top_on, e.top);
      chk($sformatf("v%0d_bot", i), bot_on, e.bot);
      chk($sformatf("v%0d_fault", i), fault, e.flt);
      chk($sformatf("v%0d_state", i), state_o, e.st);
    end
    go_bot();
    pwm_in = 1; dt_cfg = 6'd4; first = -1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (top_on && first < 0) first = i;
      if (i >= 1 && bot_on) seen = 1;
    end
    chk("dt4_latency", first, 6);
    chk("dt4_bot_off", seen, 0);
    pwm_in = 0; dt_cfg = 6'd10; first = -1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 1) pwm_in = 1;
      if (i == 3) chk("glitch_redirect", state_o, 1);
      if (i >= 1 && i < 14 && (top_on || bot_on)) seen = 1;
      if (i >= 1 && top_on && first < 0) first = i;
    end
    chk("glitch_latency", first, 14);
    chk("glitch_pulse", seen, 0);
    ft_frc = 1; fb_frc = 1;
    step();
    chk("short_top", top_on, 0); chk("short_fault", fault, 1); chk("short_state", state_o, 5);
    fault_clr = 1;
    step();
    chk("clr_blocked", state_o, 5);
    ft_frc = 0; fb_frc = 0;
    step();
    chk("clr_state", state_o, 0); chk("clr_fault", fault, 0);
    fault_clr = 0;
    go_bot();
    fb_frc = 1; pwm_in = 1; first = -1; seen = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (fault && first < 0) first = i;
      if (top_on) seen = 1;
    end
    chk("timeout_at", first, 65);
    chk("timeout_top", seen, 0);
    chk("timeout_state", state_o, 5);
    fb_frc = 0; fault_clr = 1;
    step();
    chk("to_clr_state", state_o, 0); chk("to_clr_fault", fault, 0);
    fault_clr = 0;
    go_bot();
    CELRST = 1;
    step();
    chk("rst_bot_drop", bot_on, 0); chk("rst_bot_state", state_o, 0);
    CELRST = 0;
    ft_frc = 1; fb_frc = 1;
    step();
    chk("pre_rst_fault", fault, 1);
    CELRST = 1;
    step();
    chk("rst_flt_fault", fault, 0); chk("rst_flt_state", state_o, 0);
    ft_frc = 0; fb_frc = 0; CELRST = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
